// File: rtl/sat_round_pipe.sv
// Two-stage round-and-saturate pipeline for NCH lockstep signed channels.
// Stage 1 drops SHIFT LSBs with the selected rounding mode; stage 2 clips to OSZ bits and keeps clip statistics.
module sat_round_pipe #(
  parameter int NCH   = 2,
  parameter int ISZ   = 17,
  parameter int OSZ   = 12,
  parameter int SHIFT = 0,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rnd_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ISZ-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*OSZ-1:0]    out_data,
  output logic [NCH-1:0]        out_sat,
  output logic [NCH*CNTW-1:0]   sat_cnt,
  output logic                  sat_sticky,
  input  logic                  cnt_clr
);

  localparam int RW = ISZ - SHIFT + 1;
  localparam logic [ISZ:0] ONE_C     = (ISZ+1)'(1);
  localparam logic [ISZ:0] HALF_C    = (SHIFT > 0) ? (ONE_C << ((SHIFT > 0) ? SHIFT - 1 : 0)) : (ISZ+1)'(0);
  localparam logic [ISZ:0] HALF_M1_C = (SHIFT > 0) ? (HALF_C - ONE_C) : (ISZ+1)'(0);
  localparam logic [OSZ-1:0] MAX_C   = {1'b0, {(OSZ-1){1'b1}}};
  localparam logic [OSZ-1:0] MIN_C   = {1'b1, {(OSZ-1){1'b0}}};
  localparam logic [CNTW-1:0] CNT_ONE_C = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX_C = {CNTW{1'b1}};

  // Sign-extended by one bit so the rounding bias can never overflow.
  function automatic logic [RW-1:0] round_f(input logic [ISZ-1:0] x, input logic [1:0] mode);
    logic [ISZ:0] xe;
    logic [ISZ:0] sum;
    logic         odd;
    xe  = {x[ISZ-1], x};
    odd = (SHIFT > 0) ? x[SHIFT] : 1'b0;
    case (mode)
      2'b01:   sum = xe + HALF_C;
      2'b10:   sum = xe + HALF_M1_C + {{ISZ{1'b0}}, odd};
      default: sum = xe;
    endcase
    return RW'(sum >> SHIFT);
  endfunction

  // Returns {clipped, value}; in range only if the top bits are pure sign extension.
  function automatic logic [OSZ:0] sat_f(input logic [RW-1:0] r);
    logic [RW-OSZ:0] up;
    up = r[RW-1:OSZ-1];
    if ((&up) || !(|up)) begin
      return {1'b0, r[OSZ-1:0]};
    end else if (r[RW-1]) begin
      return {1'b1, MIN_C};
    end else begin
      return {1'b1, MAX_C};
    end
  endfunction

  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [NCH*RW-1:0]    r1_q, r1_d;
  logic [NCH*OSZ-1:0]   data_q, data_d;
  logic [NCH-1:0]       sat_q, sat_d;
  logic [NCH*CNTW-1:0]  cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 en1_s, en2_s, xfer_s;

  // Handshake enables and next-state for both stages and the statistics.
  always_comb begin
    en2_s    = ~v2_q | out_ready;
    en1_s    = ~v1_q | en2_s;
    xfer_s   = v2_q & out_ready;
    in_ready = en1_s & ~reset;

    v1_d     = v1_q;
    r1_d     = r1_q;
    v2_d     = v2_q;
    data_d   = data_q;
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    if (en1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        for (int k = 0; k < NCH; k++) begin
          r1_d[k*RW +: RW] = round_f(in_data[k*ISZ +: ISZ], rnd_mode);
        end
      end else begin
        r1_d = r1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (en2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        for (int k = 0; k < NCH; k++) begin
          {sat_d[k], data_d[k*OSZ +: OSZ]} = sat_f(r1_q[k*RW +: RW]);
        end
      end else begin
        data_d = data_q;
      end
    end else begin
      v2_d = v2_q;
    end

    // Clear wins over a coincident clipped transfer.
    if (cnt_clr) begin
      cnt_d    = {(NCH*CNTW){1'b0}};
      sticky_d = 1'b0;
    end else if (xfer_s) begin
      for (int k = 0; k < NCH; k++) begin
        if (sat_q[k] && (cnt_q[k*CNTW +: CNTW] != CNT_MAX_C)) begin
          cnt_d[k*CNTW +: CNTW] = cnt_q[k*CNTW +: CNTW] + CNT_ONE_C;
        end else begin
          cnt_d[k*CNTW +: CNTW] = cnt_q[k*CNTW +: CNTW];
        end
      end
      sticky_d = sticky_q | (|sat_q);
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Pipeline and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      r1_q     <= {(NCH*RW){1'b0}};
      data_q   <= {(NCH*OSZ){1'b0}};
      sat_q    <= {NCH{1'b0}};
      cnt_q    <= {(NCH*CNTW){1'b0}};
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      r1_q     <= r1_d;
      data_q   <= data_d;
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = v2_q;
  assign out_data   = data_q;
  assign out_sat    = sat_q;
  assign sat_cnt    = cnt_q;
  assign sat_sticky = sticky_q;

endmodule
